// File: rtl/pll_phase_ctrl.sv
// Dynamic phase-shift sequencer for the EHXPLLL PHASESEL/PHASEDIR/PHASESTEP port, with lock filtering.
// Optional per-output position counters are enabled by defining PLL_PHASE_POS_EN.
module pll_phase_ctrl #(
    parameter int unsigned SETUP_CYCLES  = 4,
    parameter int unsigned PULSE_CYCLES  = 4,
    parameter int unsigned SETTLE_CYCLES = 16,
    parameter int unsigned CNT_W         = 8,
    parameter int unsigned LOCK_FILTER   = 1024
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             pll_locked,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic [1:0]       req_sel,
    input  logic             req_dir,
    input  logic [CNT_W-1:0] req_steps,
    output logic             busy,
    output logic             done,
    output logic             aborted,
    output logic             lock_stable,
    output logic [1:0]       phasesel,
    output logic             phasedir,
    output logic             phasestep
`ifdef PLL_PHASE_POS_EN
    ,
    input  logic [1:0]              pos_sel,
    output logic signed [CNT_W+1:0] pos_data
`endif
);

    localparam int unsigned POS_W   = CNT_W + 2;
    localparam int unsigned MAX_A   = (SETUP_CYCLES > PULSE_CYCLES) ? SETUP_CYCLES : PULSE_CYCLES;
    localparam int unsigned MAX_CYC = (MAX_A > SETTLE_CYCLES) ? MAX_A : SETTLE_CYCLES;
    localparam int unsigned CYC_W   = (MAX_CYC > 1) ? $clog2(MAX_CYC) : 1;
    localparam int unsigned LCNT_W  = $clog2(LOCK_FILTER + 1);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SETUP,
        ST_PULSE,
        ST_HOLD,
        ST_SETTLE
    } state_e;

    state_e             state_q, state_d;
    logic [CYC_W-1:0]   cyc_q, cyc_d;
    logic [CNT_W-1:0]   remaining_q, remaining_d;
    logic               lock_sync1_q, lock_sync2_q;
    logic [LCNT_W-1:0]  lock_cnt_q, lock_cnt_d;
    logic               lock_stable_q, lock_stable_d;
    logic               req_ready_q, req_ready_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;
    logic               aborted_q, aborted_d;
    logic [1:0]         phasesel_q, phasesel_d;
    logic               phasedir_q, phasedir_d;
    logic               phasestep_q, phasestep_d;

    logic accept, abort, setup_last, pulse_last, settle_last, pulse_cmt;

    // Lock filter: consecutive synchronized-lock cycles, saturating; any low sample clears it
    always_comb begin
        lock_cnt_d = lock_cnt_q;
        if (!lock_sync2_q) begin
            lock_cnt_d = '0;
        end else if (lock_cnt_q != LCNT_W'(LOCK_FILTER)) begin
            lock_cnt_d = lock_cnt_q + LCNT_W'(1);
        end
        lock_stable_d = lock_sync2_q && (lock_cnt_d == LCNT_W'(LOCK_FILTER));
    end

    assign accept      = (state_q == ST_IDLE) && req_valid && req_ready_q;
    assign abort       = (state_q != ST_IDLE) && !lock_stable_d;
    assign setup_last  = (cyc_q == CYC_W'(SETUP_CYCLES - 1));
    assign pulse_last  = (state_q == ST_PULSE) && (cyc_q == CYC_W'(PULSE_CYCLES - 1));
    assign settle_last = (state_q == ST_SETTLE) && (cyc_q == CYC_W'(SETTLE_CYCLES - 1));
    assign pulse_cmt   = pulse_last && !abort;

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic; lock loss overrides every transition
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_IDLE:   if (accept && (req_steps != '0)) state_d = ST_SETUP;
            ST_SETUP:  if (setup_last) state_d = ST_PULSE;
            ST_PULSE:  if (pulse_last) state_d = ST_HOLD;
            ST_HOLD:   if (setup_last) state_d = ST_SETTLE;
            ST_SETTLE: if (settle_last) state_d = (remaining_q != '0) ? ST_PULSE : ST_IDLE;
            default:   state_d = ST_IDLE;
        endcase
        if (abort) begin
            state_d = ST_IDLE;
        end
    end

    // Output and datapath next values, registered below
    always_comb begin
        cyc_d       = ((state_d != state_q) || (state_d == ST_IDLE)) ? '0 : cyc_q + CYC_W'(1);
        remaining_d = remaining_q;
        phasesel_d  = phasesel_q;
        phasedir_d  = phasedir_q;
        if (accept) begin
            remaining_d = req_steps;
            phasesel_d  = req_sel;
            phasedir_d  = req_dir;
        end else if (abort) begin
            remaining_d = '0;
        end else if (pulse_last) begin
            remaining_d = remaining_q - CNT_W'(1);
        end
        phasestep_d = (state_d != ST_PULSE);
        busy_d      = (state_d != ST_IDLE);
        req_ready_d = (state_d == ST_IDLE) && lock_stable_d;
        aborted_d   = abort;
        done_d      = (accept && (req_steps == '0))
                   || (settle_last && (remaining_q == '0) && !abort);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cyc_q         <= '0;
            remaining_q   <= '0;
            lock_sync1_q  <= 1'b0;
            lock_sync2_q  <= 1'b0;
            lock_cnt_q    <= '0;
            lock_stable_q <= 1'b0;
            req_ready_q   <= 1'b0;
            busy_q        <= 1'b0;
            done_q        <= 1'b0;
            aborted_q     <= 1'b0;
            phasesel_q    <= 2'd0;
            phasedir_q    <= 1'b1;
            phasestep_q   <= 1'b1;
        end else begin
            cyc_q         <= cyc_d;
            remaining_q   <= remaining_d;
            lock_sync1_q  <= pll_locked;
            lock_sync2_q  <= lock_sync1_q;
            lock_cnt_q    <= lock_cnt_d;
            lock_stable_q <= lock_stable_d;
            req_ready_q   <= req_ready_d;
            busy_q        <= busy_d;
            done_q        <= done_d;
            aborted_q     <= aborted_d;
            phasesel_q    <= phasesel_d;
            phasedir_q    <= phasedir_d;
            phasestep_q   <= phasestep_d;
        end
    end

    assign req_ready   = req_ready_q;
    assign busy        = busy_q;
    assign done        = done_q;
    assign aborted     = aborted_q;
    assign lock_stable = lock_stable_q;
    assign phasesel    = phasesel_q;
    assign phasedir    = phasedir_q;
    assign phasestep   = phasestep_q;

`ifdef PLL_PHASE_POS_EN
    logic [POS_W-1:0] pos_q [4];
    logic [POS_W-1:0] pos_d [4];
    logic [POS_W-1:0] pos_data_q, pos_data_d;

    // Position tracking per select; modulo arithmetic gives the two's-complement wrap
    always_comb begin
        for (int i = 0; i < 4; i++) begin
            pos_d[i] = pos_q[i];
        end
        if (pulse_cmt) begin
            pos_d[phasesel_q] = phasedir_q ? (pos_q[phasesel_q] - POS_W'(1))
                                           : (pos_q[phasesel_q] + POS_W'(1));
        end
        pos_data_d = pos_q[pos_sel];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 4; i++) begin
                pos_q[i] <= '0;
            end
            pos_data_q <= '0;
        end else begin
            for (int i = 0; i < 4; i++) begin
                pos_q[i] <= pos_d[i];
            end
            pos_data_q <= pos_data_d;
        end
    end

    assign pos_data = $signed(pos_data_q);
`else
    logic unused_pulse_cmt;
    assign unused_pulse_cmt = pulse_cmt;
`endif

endmodule

// File: tb/tb_pll_phase_ctrl.sv
// Directed self-checking bench for pll_phase_ctrl; position-counter checks run when PLL_PHASE_POS_EN is defined.
module tb_pll_phase_ctrl;

    logic       clk;
    logic       rst_n;
    logic       pll_locked;
    logic       req_valid;
    logic       req_ready;
    logic [1:0] req_sel;
    logic       req_dir;
    logic [7:0] req_steps;
    logic       busy;
    logic       done;
    logic       aborted;
    logic       lock_stable;
    logic [1:0] phasesel;
    logic       phasedir;
    logic       phasestep;
`ifdef PLL_PHASE_POS_EN
    logic [1:0]        pos_sel;
    logic signed [9:0] pos_data;
`endif

    int vectors;
    int miscompares;

    pll_phase_ctrl dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .pll_locked  (pll_locked),
        .req_valid   (req_valid),
        .req_ready   (req_ready),
        .req_sel     (req_sel),
        .req_dir     (req_dir),
        .req_steps   (req_steps),
        .busy        (busy),
        .done        (done),
        .aborted     (aborted),
        .lock_stable (lock_stable),
        .phasesel    (phasesel),
        .phasedir    (phasedir),
        .phasestep   (phasestep)
`ifdef PLL_PHASE_POS_EN
        ,
        .pos_sel     (pos_sel),
        .pos_data    (pos_data)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk1(input string tag, input logic obs, input logic exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    task automatic chki(input string tag, input int obs, input int exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic wait_done(input int lim, output bit seen);
        seen = 1'b0;
        for (int i = 0; i < lim && !seen; i++) begin
            if (done) seen = 1'b1;
            else @(negedge clk);
        end
    endtask

    task automatic run_req(input logic [1:0] s, input logic d, input logic [7:0] n);
        bit seen;
        req_sel   = s;
        req_dir   = d;
        req_steps = n;
        req_valid = 1'b1;
        @(negedge clk);
        req_valid = 1'b0;
        wait_done(int'(n) * 24 + 40, seen);
        chki("req_done_seen", int'(seen), 1);
    endtask

`ifdef PLL_PHASE_POS_EN
    task automatic read_pos(input logic [1:0] s, input int exp);
        pos_sel = s;
        @(negedge clk);
        chki("pos_data", int'(pos_data), exp);
    endtask
`endif

    initial begin
        int  lows, falls, first_fall, second_fall, done_cnt, done_k, abort_cnt;
        logic prev;
        bit  seen, any_busy, any_ready;

        vectors     = 0;
        miscompares = 0;
        rst_n       = 1'b0;
        pll_locked  = 1'b1;
        req_valid   = 1'b0;
        req_sel     = 2'd0;
        req_dir     = 1'b0;
        req_steps   = 8'd0;
`ifdef PLL_PHASE_POS_EN
        pos_sel     = 2'd0;
`endif

        // Reset state
        repeat (2) @(negedge clk);
        chk1("rst_phasestep", phasestep, 1'b1);
        chki("rst_phasesel", int'(phasesel), 0);
        chk1("rst_phasedir", phasedir, 1'b1);
        chk1("rst_busy", busy, 1'b0);
        chk1("rst_done", done, 1'b0);
        chk1("rst_aborted", aborted, 1'b0);
        chk1("rst_lock_stable", lock_stable, 1'b0);
        chk1("rst_req_ready", req_ready, 1'b0);
        rst_n = 1'b1;

        // Lock filter: stable exactly 1026 edges after reset release
        repeat (1025) @(negedge clk);
        chk1("lock_1025", lock_stable, 1'b0);
        chk1("ready_1025", req_ready, 1'b0);
        @(negedge clk);
        chk1("lock_1026", lock_stable, 1'b1);
        chk1("ready_1026", req_ready, 1'b1);

`ifdef PLL_PHASE_POS_EN
        run_req(2'd1, 1'b0, 8'd5);
        run_req(2'd1, 1'b1, 8'd2);
        read_pos(2'd0, 0);
        read_pos(2'd1, 3);
        read_pos(2'd2, 0);
        read_pos(2'd3, 0);
        run_req(2'd3, 1'b0, 8'd255);
        run_req(2'd3, 1'b0, 8'd255);
        run_req(2'd3, 1'b0, 8'd1);
        read_pos(2'd3, 511);
        run_req(2'd3, 1'b0, 8'd1);
        read_pos(2'd3, -512);
`endif

        // Three-step request on select 2
        req_sel   = 2'd2;
        req_dir   = 1'b0;
        req_steps = 8'd3;
        req_valid = 1'b1;
        @(negedge clk);
        req_valid = 1'b0;
        chk1("t2_busy_t1", busy, 1'b1);
        chki("t2_sel_t1", int'(phasesel), 2);
        chk1("t2_dir_t1", phasedir, 1'b0);
        chk1("t2_ready_t1", req_ready, 1'b0);
        lows = 0; falls = 0; first_fall = 0; second_fall = 0; done_cnt = 0; done_k = 0;
        prev = 1'b1;
        for (int k = 1; k <= 80; k++) begin
            if (!phasestep) lows++;
            if (prev && !phasestep) begin
                falls++;
                if (falls == 1) first_fall = k;
                if (falls == 2) second_fall = k;
            end
            prev = phasestep;
            if (done) begin
                done_cnt++;
                done_k = k;
            end
            if (k < 80) @(negedge clk);
        end
        chki("t2_falls", falls, 3);
        chki("t2_low_cycles", lows, 12);
        chki("t2_first_fall", first_fall, 5);
        chki("t2_period", second_fall - first_fall, 24);
        chki("t2_done_count", done_cnt, 1);
        chki("t2_done_cycle", done_k, 77);
        chk1("t2_busy_end", busy, 1'b0);
        chk1("t2_step_end", phasestep, 1'b1);

        // Zero-step request
        req_sel   = 2'd1;
        req_dir   = 1'b1;
        req_steps = 8'd0;
        req_valid = 1'b1;
        @(negedge clk);
        req_valid = 1'b0;
        chk1("t3_done", done, 1'b1);
        chk1("t3_busy", busy, 1'b0);
        chk1("t3_step", phasestep, 1'b1);
        chk1("t3_ready", req_ready, 1'b1);
        @(negedge clk);
        chk1("t3_done_clr", done, 1'b0);
        chk1("t3_busy2", busy, 1'b0);
        chk1("t3_step2", phasestep, 1'b1);

        // Request held valid across a running sequence
        req_sel   = 2'd1;
        req_dir   = 1'b1;
        req_steps = 8'd1;
        req_valid = 1'b1;
        @(negedge clk);
        req_sel   = 2'd3;
        req_dir   = 1'b0;
        chki("t5_sel_a", int'(phasesel), 1);
        chk1("t5_dir_a", phasedir, 1'b1);
        repeat (27) @(negedge clk);
        chki("t5_sel_a_late", int'(phasesel), 1);
        chk1("t5_busy_a_late", busy, 1'b1);
        chk1("t5_ready_a_late", req_ready, 1'b0);
        @(negedge clk);
        chk1("t5_done_a", done, 1'b1);
        chk1("t5_ready_idle", req_ready, 1'b1);
        @(negedge clk);
        req_valid = 1'b0;
        chki("t5_sel_b", int'(phasesel), 3);
        chk1("t5_dir_b", phasedir, 1'b0);
        chk1("t5_busy_b", busy, 1'b1);
        wait_done(60, seen);
        chki("t5_done_b", int'(seen), 1);

        // Lock loss during the second pulse of five
        @(negedge clk);
        req_sel   = 2'd0;
        req_dir   = 1'b1;
        req_steps = 8'd5;
        req_valid = 1'b1;
        @(negedge clk);
        req_valid = 1'b0;
        repeat (28) @(negedge clk);
        chk1("t4_pulse2_low", phasestep, 1'b0);
        pll_locked = 1'b0;
        @(negedge clk);
        chk1("t4_k30_low", phasestep, 1'b0);
        @(negedge clk);
        chk1("t4_k31_low", phasestep, 1'b0);
        chk1("t4_k31_abort", aborted, 1'b0);
        @(negedge clk);
        chk1("t4_step_high", phasestep, 1'b1);
        chk1("t4_aborted", aborted, 1'b1);
        chk1("t4_no_done", done, 1'b0);
        chk1("t4_busy", busy, 1'b0);
        chk1("t4_lock", lock_stable, 1'b0);
        chk1("t4_ready", req_ready, 1'b0);
        abort_cnt = 0;
        done_cnt  = 0;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            if (aborted) abort_cnt++;
            if (done) done_cnt++;
        end
        chki("t4_abort_once", abort_cnt, 0);
        chki("t4_done_never", done_cnt, 0);
        pll_locked = 1'b1;
        req_steps  = 8'd2;
        req_valid  = 1'b1;
        any_busy   = 1'b0;
        any_ready  = 1'b0;
        for (int k = 0; k < 1025; k++) begin
            @(negedge clk);
            if (busy) any_busy = 1'b1;
            if (req_ready) any_ready = 1'b1;
        end
        chki("t4_no_accept", int'(any_busy), 0);
        chki("t4_no_ready", int'(any_ready), 0);
        @(negedge clk);
        req_valid = 1'b0;
        chk1("t4_relock", lock_stable, 1'b1);
        chk1("t4_ready_relock", req_ready, 1'b1);

        // Asynchronous reset in the middle of a pulse
        @(negedge clk);
        req_sel   = 2'd2;
        req_dir   = 1'b0;
        req_steps = 8'd1;
        req_valid = 1'b1;
        @(negedge clk);
        req_valid = 1'b0;
        repeat (4) @(negedge clk);
        chk1("rst_mid_low", phasestep, 1'b0);
        #2;
        rst_n = 1'b0;
        #1;
        chk1("rst_mid_step", phasestep, 1'b1);
        chk1("rst_mid_busy", busy, 1'b0);
        chk1("rst_mid_lock", lock_stable, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
